instr_mem_ctrl: RTL and testbench

- Parametrised, bootloadable instruction memory for the RISC-V SoC fetch path; the next generation of the fixed 5-entry instruction ROM.
- Sits behind the bus decoder as slave 1 and serves PC fetches with a valid handshake and a configurable wait-state count.
- Flags misaligned and out-of-range fetches.
- Contents are loaded byte-by-byte by the bootloader during a boot phase, not hard-coded.

---
 rtl/soc_mem_pkg.sv | 26 ++
 rtl/imem_array.sv | 31 +++
 rtl/instr_mem_ctrl.sv | 129 ++++++++++++
 tb/tb_instr_mem_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_mem_pkg
// Description : Shared FSM type, constants and helpers for SoC memories.
// Revision    : 1.0  initial release
// ============================================================================
package soc_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        RESP = ST_RESP
    } imem_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module      : imem_array
// Description : DEPTH x 32 storage, byte-lane writes, registered read port.
// Revision    : 1.0  initial release
// ============================================================================
module imem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [1:0]    wr_lane,
    input  logic [IW-1:0] wr_idx,
    input  logic [7:0]    wr_byte,
    input  logic [IW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    // Left unreset so the array maps onto block RAM.
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx][{wr_lane, 3'b000} +: 8] <= wr_byte;
        end
        rd_data <= mem_q[rd_idx];
    end

endmodule
`default_nettype wire

// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_ctrl
// Description : Bootloadable instruction memory, bus slave 1 on the fetch path.
// Revision    : 1.0  initial release
// ============================================================================
module instr_mem_ctrl
    import soc_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] FAULT_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        boot_mode,
    input  logic        boot_wr_en,
    input  logic [31:0] boot_wr_addr,
    input  logic [7:0]  boot_wr_data,
    output logic        boot_err,
    input  logic        HSEL1,
    input  logic        rd_en_rom,
    input  logic [31:0] address_rom,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        fault,
    output logic        busy
);

    localparam int unsigned AW      = $clog2(DEPTH * 4);
    localparam logic [31:0] C_BYTES = 32'(DEPTH * 4);
    localparam logic [3:0]  C_WS_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    imem_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic [AW-3:0] idx_q, idx_d;
    logic          boot_err_q, boot_err_d;

    logic          w_accept;
    logic          w_boot_wr;
    logic          w_wr_in_range;
    logic          w_mem_we;
    logic [AW-3:0] w_rd_idx;
    logic [31:0]   w_rd_data;

    assign w_accept      = (state_q == IDLE) && !boot_mode && HSEL1 && rd_en_rom;
    assign w_boot_wr     = boot_mode && boot_wr_en;
    assign w_wr_in_range = (boot_wr_addr < C_BYTES);
    assign w_mem_we      = w_boot_wr && w_wr_in_range;

    // In IDLE the array is addressed straight from the bus so a zero-wait
    // fetch has its word ready in the very next cycle.
    assign w_rd_idx = (state_q == IDLE) ? address_rom[AW-1:2] : idx_q;

    imem_array #(
        .DEPTH (DEPTH),
        .IW    (AW - 2)
    ) u_array (
        .clk     (clk),
        .we      (w_mem_we),
        .wr_lane (boot_wr_addr[1:0]),
        .wr_idx  (boot_wr_addr[AW-1:2]),
        .wr_byte (boot_wr_data),
        .rd_idx  (w_rd_idx),
        .rd_data (w_rd_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fault_d    = fault_q;
        idx_d      = idx_q;
        boot_err_d = boot_err_q | (w_boot_wr && !w_wr_in_range);

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    idx_d   = address_rom[AW-1:2];
                    fault_d = !is_word_aligned(address_rom[1:0]) ||
                              (address_rom >= C_BYTES);
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = C_WS_INIT;
                    end
                end
            end
            WAIT: begin
                if (boot_mode) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            fault_q    <= 1'b0;
            idx_q      <= '0;
            boot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
            idx_q      <= idx_d;
            boot_err_q <= boot_err_d;
        end
    end

    assign instr_valid = (state_q == RESP);
    assign fault       = instr_valid && fault_q;
    assign instruction = !instr_valid ? 32'h0 :
                         fault_q      ? FAULT_INSTR : w_rd_data;
    assign busy        = (state_q != IDLE);
    assign boot_err    = boot_err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_ctrl
// Description : Self-checking bench: zero-wait and three-wait instances.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instr_mem_ctrl;
    import soc_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        boot_mode, boot_wr_en, HSEL1, rd_en_rom;
    logic [31:0] boot_wr_addr, address_rom;
    logic [7:0]  boot_wr_data;

    logic [31:0] d0_instr, d3_instr;
    logic        d0_valid, d0_fault, d0_busy, d0_berr;
    logic        d3_valid, d3_fault, d3_busy, d3_berr;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    instr_mem_ctrl #(.DEPTH(256), .WAIT_STATES(0), .FAULT_INSTR(32'h0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .boot_mode(boot_mode), .boot_wr_en(boot_wr_en),
        .boot_wr_addr(boot_wr_addr), .boot_wr_data(boot_wr_data), .boot_err(d0_berr),
        .HSEL1(HSEL1), .rd_en_rom(rd_en_rom), .address_rom(address_rom),
        .instruction(d0_instr), .instr_valid(d0_valid), .fault(d0_fault), .busy(d0_busy));

    instr_mem_ctrl #(.DEPTH(256), .WAIT_STATES(3), .FAULT_INSTR(NOP_INSTR)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .boot_mode(boot_mode), .boot_wr_en(boot_wr_en),
        .boot_wr_addr(boot_wr_addr), .boot_wr_data(boot_wr_data), .boot_err(d3_berr),
        .HSEL1(HSEL1), .rd_en_rom(rd_en_rom), .address_rom(address_rom),
        .instruction(d3_instr), .instr_valid(d3_valid), .fault(d3_fault), .busy(d3_busy));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Reference model: a byte memory plus, per instance, "in flight" and the
    // number of cycles left until the response is due.
    logic [7:0]  m_mem [0:1023];
    bit          m_busy [2];
    int          m_rem  [2];
    logic [31:0] m_addr [2];
    bit          m_flt  [2];
    bit          m_berr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) m_busy[k] <= 1'b0;
            m_berr <= 1'b0;
        end else begin
            if (boot_mode && boot_wr_en) begin
                if (boot_wr_addr < 32'd1024) m_mem[int'(boot_wr_addr)] <= boot_wr_data;
                else m_berr <= 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                if (m_busy[k]) begin
                    if (boot_mode || m_rem[k] == 0) m_busy[k] <= 1'b0;
                    else m_rem[k] <= m_rem[k] - 1;
                end else if (!boot_mode && HSEL1 && rd_en_rom) begin
                    m_busy[k] <= 1'b1;
                    m_rem[k]  <= (k == 0) ? 0 : 3;
                    m_addr[k] <= address_rom;
                    m_flt[k]  <= (address_rom % 4 != 0) || (address_rom >= 32'd1024);
                end
            end
        end
    end

    task automatic check_dut(input int k, input logic [31:0] instr, input logic v,
                             input logic f, input logic b, input logic be);
        logic        ev, ef;
        logic [31:0] ei;
        int          a;
        ev = m_busy[k] && (m_rem[k] == 0);
        ef = ev && m_flt[k];
        a  = int'(m_addr[k] % 1024);
        if (!ev)          ei = 32'h0;
        else if (m_flt[k]) ei = (k == 0) ? 32'h0 : NOP_INSTR;
        else              ei = {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
        check($sformatf("model.dut%0d.valid", k), {31'b0, v},  {31'b0, ev});
        check($sformatf("model.dut%0d.fault", k), {31'b0, f},  {31'b0, ef});
        check($sformatf("model.dut%0d.instr", k), instr, ei);
        check($sformatf("model.dut%0d.busy", k),  {31'b0, b},  {31'b0, m_busy[k]});
        check($sformatf("model.dut%0d.berr", k),  {31'b0, be}, {31'b0, m_berr});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut(0, d0_instr, d0_valid, d0_fault, d0_busy, d0_berr);
            check_dut(1, d3_instr, d3_valid, d3_fault, d3_busy, d3_berr);
        end
    end

    typedef struct {
        logic        hsel;
        logic        rd;
        logic [31:0] addr;
        logic        valid;
        logic        fault;
        logic [31:0] instr;
    } vec_t;

    vec_t vec [8];

    task automatic boot_wr(input logic [31:0] a, input logic [7:0] d);
        boot_mode = 1'b1; boot_wr_en = 1'b1; boot_wr_addr = a; boot_wr_data = d;
        @(posedge clk); #1;
        boot_wr_en = 1'b0;
    endtask

    task automatic fetch_pulse(input logic [31:0] a);
        HSEL1 = 1'b1; rd_en_rom = 1'b1; address_rom = a;
        @(posedge clk); #1;
        HSEL1 = 1'b0; rd_en_rom = 1'b0;
    endtask

    initial begin
        // Zero-wait instance, expected in the cycle right after the request.
        vec[0] = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0020_81B3};
        vec[1] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vec[2] = '{1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b1, 32'h0000_0000};
        vec[3] = '{1'b1, 1'b1, 32'h0000_0400, 1'b1, 1'b1, 32'h0000_0000};
        vec[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0000};
        vec[5] = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
        vec[6] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
        vec[7] = '{1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0000};

        reset_n = 1'b0; boot_mode = 1'b0; boot_wr_en = 1'b0; boot_wr_addr = '0;
        boot_wr_data = '0; HSEL1 = 1'b0; rd_en_rom = 1'b0; address_rom = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.instr", d0_instr, 32'h0);
        check("rst.valid", {31'b0, d0_valid | d3_valid}, 32'h0);
        check("rst.fault", {31'b0, d0_fault | d3_fault}, 32'h0);
        check("rst.busy",  {31'b0, d0_busy | d3_busy},   32'h0);
        check("rst.berr",  {31'b0, d0_berr | d3_berr},   32'h0);
        @(negedge clk); reset_n = 1'b1; chk_en = 1'b1;
        @(posedge clk); #1;

        boot_wr(32'h0, 8'hB3); boot_wr(32'h1, 8'h81);
        boot_wr(32'h2, 8'h20); boot_wr(32'h3, 8'h00);
        boot_wr(32'h8, 8'hEF); boot_wr(32'h9, 8'hBE);
        boot_wr(32'hA, 8'hAD); boot_wr(32'hB, 8'hDE);
        boot_mode = 1'b0;
        // Write strobe with boot_mode low must not touch the array.
        boot_wr_en = 1'b1; boot_wr_addr = 32'h0; boot_wr_data = 8'hFF;
        @(posedge clk); #1; boot_wr_en = 1'b0;

        // Out-of-range write aliases word 0 if the range check were truncated.
        boot_wr(32'h400, 8'h55);
        boot_mode = 1'b0;
        @(negedge clk);
        check("boot_range.berr0", {31'b0, d0_berr}, 32'h1);
        check("boot_range.berr3", {31'b0, d3_berr}, 32'h1);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            HSEL1 = vec[i].hsel; rd_en_rom = vec[i].rd; address_rom = vec[i].addr;
            @(posedge clk); #1;
            HSEL1 = 1'b0; rd_en_rom = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d.valid", i), {31'b0, d0_valid}, {31'b0, vec[i].valid});
            check($sformatf("vec%0d.fault", i), {31'b0, d0_fault}, {31'b0, vec[i].fault});
            check($sformatf("vec%0d.instr", i), d0_instr, vec[i].instr);
            repeat (5) @(posedge clk);
            #1;
        end

        check("boot_range.sticky", {31'b0, d0_berr & d3_berr}, 32'h1);
        #2 reset_n = 1'b0;
        #1 check("boot_range.cleared", {31'b0, d0_berr | d3_berr}, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Held request on the three-wait instance: busy 1..4, valid only in 4,
        // idle in 5 (request in RESP ignored), re-accepted for cycle 6.
        HSEL1 = 1'b1; rd_en_rom = 1'b1; address_rom = 32'h8;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("ws.c%0d.busy", c),  {31'b0, d3_busy},  {31'b0, (c != 5)});
            check($sformatf("ws.c%0d.valid", c), {31'b0, d3_valid}, {31'b0, (c == 4)});
            if (c == 4) check("ws.instr", d3_instr, 32'hDEAD_BEEF);
        end
        HSEL1 = 1'b0; rd_en_rom = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // boot_mode raised while the three-wait fetch sits in WAIT.
        fetch_pulse(32'h8);
        boot_mode = 1'b1;
        @(negedge clk);
        check("abort.dut0_valid", {31'b0, d0_valid}, 32'h1);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("abort.c%0d.valid", c), {31'b0, d3_valid}, 32'h0);
            check($sformatf("abort.c%0d.busy", c),  {31'b0, d3_busy},  32'h0);
        end
        @(posedge clk); #1;
        boot_mode = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of WAIT; memory must survive.
        fetch_pulse(32'h0);
        @(posedge clk); #2;
        check("rstw.pre_busy", {31'b0, d3_busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("rstw.busy",  {31'b0, d3_busy},  32'h0);
        check("rstw.valid", {31'b0, d3_valid}, 32'h0);
        check("rstw.fault", {31'b0, d3_fault}, 32'h0);
        check("rstw.instr", d3_instr, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        fetch_pulse(32'h0);
        @(negedge clk);
        check("rstw.refetch_valid", {31'b0, d0_valid}, 32'h1);
        check("rstw.refetch_instr", d0_instr, 32'h0020_81B3);
        repeat (5) @(posedge clk);
        #1;

        // Fill the whole array, then random traffic against the model.
        for (int a = 0; a < 1024; a++) boot_wr(32'(a), 8'($urandom));
        boot_mode = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            boot_mode    = ($urandom_range(0, 9) == 0);
            boot_wr_en   = 1'($urandom_range(0, 1));
            boot_wr_addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            boot_wr_data = 8'($urandom);
            HSEL1        = ($urandom_range(0, 3) != 0);
            rd_en_rom    = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0, 1, 2: address_rom = 32'($urandom_range(0, 255)) * 4;
                3:       address_rom = 32'($urandom_range(0, 1023)) | 32'h1;
                4:       address_rom = $urandom;
                default: address_rom = 32'hFFFF_FFFC;
            endcase
            @(posedge clk); #1;
        end
        boot_mode = 1'b0; boot_wr_en = 1'b0; HSEL1 = 1'b0; rd_en_rom = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
